// File: rtl/pll_lock_reset_sequencer.sv
// pll_lock_reset_sequencer
// Drives the PLL reset, qualifies the (asynchronous) lock indication and then
// releases the downstream domain resets one at a time in ascending index order.
// On a lock timeout the PLL is reset again. On a lock loss after release has
// begun, every domain goes back into reset and the PLL is reset again.
//
// Ports:
//   refclk        reference clock (the only clock)
//   rst           synchronous active-high reset
//   pll_locked    PLL lock indication, asynchronous to refclk
//   pll_rst       PLL reset, active high
//   domain_rst    per-domain resets, active high, released 0..NUM_STAGES-1
//   sys_ready     all domains released and lock still held
//   lock_loss_cnt saturating count of lock losses during RELEASE/RUN
//   timeout_cnt   saturating count of WAIT_LOCK timeouts
//   state         0 PLL_RESET, 1 WAIT_LOCK, 2 STABLE, 3 RELEASE, 4 RUN
module pll_lock_reset_sequencer #(
    parameter int unsigned NUM_STAGES     = 2,
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 65535,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned STAGE_GAP      = 64,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  pll_locked,
    output logic                  pll_rst,
    output logic [NUM_STAGES-1:0] domain_rst,
    output logic                  sys_ready,
    output logic [CNT_W-1:0]      lock_loss_cnt,
    output logic [CNT_W-1:0]      timeout_cnt,
    output logic [2:0]            state
);

    // One shared timer covers the longest interval any state has to measure.
    localparam int unsigned TMax01 = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES
                                                                      : LOCK_TIMEOUT;
    localparam int unsigned TMax23 = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
    localparam int unsigned TMax   = (TMax01 > TMax23) ? TMax01 : TMax23;
    localparam int unsigned TW     = $clog2(TMax + 1);
    localparam int unsigned IW     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    typedef enum logic [2:0] {
        StPllReset = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRelease  = 3'd3,
        StRun      = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  pll_rst_q, pll_rst_d;
    logic [NUM_STAGES-1:0] dom_q, dom_d;
    logic                  ready_q, ready_d;
    logic [CNT_W-1:0]      ll_cnt_q, ll_cnt_d;
    logic [CNT_W-1:0]      to_cnt_q, to_cnt_d;
    logic                  sync1_q, sync2_q;
    logic                  locked_s;

    assign locked_s = sync2_q;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        idx_d     = idx_q;
        pll_rst_d = pll_rst_q;
        dom_d     = dom_q;
        ready_d   = ready_q;
        ll_cnt_d  = ll_cnt_q;
        to_cnt_d  = to_cnt_q;
        case (state_q)
            StPllReset: begin
                pll_rst_d = 1'b1;
                if (timer_q == TW'(PLL_RST_CYCLES - 1)) begin
                    state_d   = StWaitLock;
                    pll_rst_d = 1'b0;
                    timer_d   = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StWaitLock: begin
                if (locked_s) begin
                    state_d = StStable;
                    timer_d = '0;
                end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
                    state_d   = StPllReset;
                    pll_rst_d = 1'b1;
                    timer_d   = '0;
                    if (to_cnt_q != '1) to_cnt_d = to_cnt_q + CNT_W'(1);
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StStable: begin
                // Any dropout restarts qualification from scratch.
                if (!locked_s) begin
                    state_d = StWaitLock;
                    timer_d = '0;
                end else if (timer_q == TW'(STABLE_CYCLES - 1)) begin
                    state_d = StRelease;
                    timer_d = '0;
                    idx_d   = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StRelease, StRun: begin
                // Lock loss wins over a coincident stage release or RUN entry.
                if (!locked_s) begin
                    state_d   = StPllReset;
                    pll_rst_d = 1'b1;
                    dom_d     = '1;
                    ready_d   = 1'b0;
                    timer_d   = '0;
                    idx_d     = '0;
                    if (ll_cnt_q != '1) ll_cnt_d = ll_cnt_q + CNT_W'(1);
                end else if (state_q == StRelease) begin
                    if (timer_q == TW'(STAGE_GAP - 1)) begin
                        dom_d[idx_q] = 1'b0;
                        timer_d      = '0;
                        idx_d        = idx_q + IW'(1);
                        if (idx_q == IW'(NUM_STAGES - 1)) begin
                            state_d = StRun;
                            ready_d = 1'b1;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            default: begin
                // Illegal encodings recover to the reset condition.
                state_d   = StPllReset;
                pll_rst_d = 1'b1;
                dom_d     = '1;
                ready_d   = 1'b0;
                timer_d   = '0;
                idx_d     = '0;
            end
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= StPllReset;
            timer_q   <= '0;
            idx_q     <= '0;
            pll_rst_q <= 1'b1;
            dom_q     <= '1;
            ready_q   <= 1'b0;
            ll_cnt_q  <= '0;
            to_cnt_q  <= '0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            pll_rst_q <= pll_rst_d;
            dom_q     <= dom_d;
            ready_q   <= ready_d;
            ll_cnt_q  <= ll_cnt_d;
            to_cnt_q  <= to_cnt_d;
            sync1_q   <= pll_locked;
            sync2_q   <= sync1_q;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign domain_rst    = dom_q;
    assign sys_ready     = ready_q;
    assign lock_loss_cnt = ll_cnt_q;
    assign timeout_cnt   = to_cnt_q;
    assign state         = state_q;

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// Testbench for pll_lock_reset_sequencer: directed scenarios plus random lock
// patterns, all outputs compared every cycle against a phase/elapsed-time model.
module tb_pll_lock_reset_sequencer;

    localparam int unsigned P   = 4;
    localparam int unsigned S   = 8;
    localparam int unsigned G   = 4;
    localparam int unsigned N   = 2;
    localparam int unsigned LT  = 10;
    localparam int unsigned CW  = 2;
    localparam int          SAT = (1 << CW) - 1;

    logic          refclk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_locked = 1'b0;
    logic          pll_rst;
    logic [N-1:0]  domain_rst;
    logic          sys_ready;
    logic [CW-1:0] lock_loss_cnt;
    logic [CW-1:0] timeout_cnt;
    logic [2:0]    state;

    int checks = 0;
    int errors = 0;

    always #5 refclk = ~refclk;

    pll_lock_reset_sequencer #(
        .NUM_STAGES    (N),
        .PLL_RST_CYCLES(P),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (S),
        .STAGE_GAP     (G),
        .CNT_W         (CW)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .pll_rst      (pll_rst),
        .domain_rst   (domain_rst),
        .sys_ready    (sys_ready),
        .lock_loss_cnt(lock_loss_cnt),
        .timeout_cnt  (timeout_cnt),
        .state        (state)
    );

    // Model: phase number, edge at which the phase was entered, number of
    // domains released, the two counters, and a 2-deep history of pll_locked.
    int m_phase = 0;
    int m_start = 0;
    int m_rel   = 0;
    int m_ll    = 0;
    int m_to    = 0;
    int cyc     = 0;
    int edge_n  = 0;
    bit hist[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    task automatic enter(input int p);
        m_phase = p;
        m_start = cyc;
    endtask

    task automatic model_step(input bit r, input bit lk);
        bit ls;
        int el;
        cyc++;
        if (r) begin
            m_phase = 0;
            m_start = cyc;
            m_rel   = 0;
            m_ll    = 0;
            m_to    = 0;
            edge_n  = 0;
            hist.delete();
            hist.push_back(1'b0);
            hist.push_back(1'b0);
            return;
        end
        edge_n++;
        ls = hist.pop_front();
        hist.push_back(lk);
        el = cyc - m_start;
        case (m_phase)
            0: if (el == int'(P)) enter(1);
            1: begin
                if (ls) enter(2);
                else if (el == int'(LT)) begin
                    enter(0);
                    m_to = sat_inc(m_to);
                end
            end
            2: begin
                if (!ls) enter(1);
                else if (el == int'(S)) begin
                    enter(3);
                    m_rel = 0;
                end
            end
            default: begin
                if (!ls) begin
                    m_ll  = sat_inc(m_ll);
                    m_rel = 0;
                    enter(0);
                end else if (m_phase == 3) begin
                    m_rel = el / int'(G);
                    if (m_rel == int'(N)) enter(4);
                end
            end
        endcase
    endtask

    task automatic tick();
        logic [N-1:0] exp_dom;
        @(posedge refclk);
        model_step(rst, pll_locked);
        #1;
        for (int k = 0; k < int'(N); k++) exp_dom[k] = (k >= m_rel);
        check("pll_rst", 32'(pll_rst), 32'(m_phase == 0));
        check("domain_rst", 32'(domain_rst), 32'(exp_dom));
        check("sys_ready", 32'(sys_ready), 32'(m_phase == 4));
        check("state", 32'(state), 32'(m_phase));
        check("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_ll));
        check("timeout_cnt", 32'(timeout_cnt), 32'(m_to));
        @(negedge refclk);
    endtask

    task automatic do_reset(input bit lk);
        rst = 1'b1;
        pll_locked = lk;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // edge_n advances on every tick with rst low, so this loop is bounded.
    task automatic run_to(input int e);
        while (edge_n < e) tick();
    endtask

    initial begin
        hist.push_back(1'b0);
        hist.push_back(1'b0);
        @(negedge refclk);

        // Reset values.
        do_reset(1'b1);
        check("rst_pll_rst", 32'(pll_rst), 32'd1);
        check("rst_domain", 32'(domain_rst), 32'd3);
        check("rst_state", 32'(state), 32'd0);

        // Case 1: lock high from reset, then case 4: lock loss in RUN.
        run_to(4);
        check("c1_pll_rst_e4", 32'(pll_rst), 32'd0);
        run_to(5);
        check("c1_state_e5", 32'(state), 32'd2);
        run_to(16);
        check("c1_dom_e16", 32'(domain_rst), 32'd3);
        run_to(17);
        check("c1_dom_e17", 32'(domain_rst), 32'd2);
        run_to(20);
        check("c1_ready_e20", 32'(sys_ready), 32'd0);
        run_to(21);
        check("c1_dom_e21", 32'(domain_rst), 32'd0);
        check("c1_ready_e21", 32'(sys_ready), 32'd1);
        check("c1_cnts", 32'({lock_loss_cnt, timeout_cnt}), 32'd0);
        run_to(25);
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        run_to(28);
        check("c4_dom", 32'(domain_rst), 32'd3);
        check("c4_ready", 32'(sys_ready), 32'd0);
        check("c4_pll_rst", 32'(pll_rst), 32'd1);
        check("c4_ll_cnt", 32'(lock_loss_cnt), 32'd1);
        check("c4_state", 32'(state), 32'd0);
        run_to(45);
        check("c4_dom_re", 32'(domain_rst), 32'd2);
        run_to(49);
        check("c4_ready_re", 32'(sys_ready), 32'd1);

        // Case 3: one-cycle glitch in STABLE.
        do_reset(1'b1);
        run_to(8);
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        run_to(11);
        check("c3_state", 32'(state), 32'd1);
        check("c3_dom", 32'(domain_rst), 32'd3);
        run_to(23);
        check("c3_dom_e23", 32'(domain_rst), 32'd3);
        run_to(24);
        check("c3_dom_e24", 32'(domain_rst), 32'd2);
        check("c3_ll_cnt", 32'(lock_loss_cnt), 32'd0);

        // Case 5: loss in RELEASE, coinciding with the final release edge.
        do_reset(1'b1);
        run_to(18);
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        run_to(21);
        check("c5_dom", 32'(domain_rst), 32'd3);
        check("c5_ready", 32'(sys_ready), 32'd0);
        check("c5_ll_cnt", 32'(lock_loss_cnt), 32'd1);
        check("c5_state", 32'(state), 32'd0);

        // Case 5b: rst mid-RELEASE.
        do_reset(1'b1);
        run_to(18);
        rst = 1'b1;
        tick();
        check("c5b_state", 32'(state), 32'd0);
        check("c5b_dom", 32'(domain_rst), 32'd3);
        check("c5b_pll_rst", 32'(pll_rst), 32'd1);
        rst = 1'b0;

        // Cases 2 and 6: no lock, repeated timeouts with saturation.
        do_reset(1'b0);
        run_to(4);
        check("c2_pll_rst_e4", 32'(pll_rst), 32'd0);
        run_to(13);
        check("c2_pll_rst_e13", 32'(pll_rst), 32'd0);
        run_to(14);
        check("c2_pll_rst_e14", 32'(pll_rst), 32'd1);
        check("c6_to_1", 32'(timeout_cnt), 32'd1);
        run_to(28);
        check("c6_to_2", 32'(timeout_cnt), 32'd2);
        run_to(42);
        check("c6_to_3", 32'(timeout_cnt), 32'd3);
        run_to(56);
        check("c6_to_4", 32'(timeout_cnt), 32'd3);
        run_to(70);
        check("c6_to_5", 32'(timeout_cnt), 32'd3);

        // Random lock patterns with occasional resets.
        for (int ep = 0; ep < 30; ep++) begin
            if ($urandom_range(0, 3) == 0) do_reset(1'($urandom_range(0, 1)));
            for (int seg = 0; seg < int'($urandom_range(1, 6)); seg++) begin
                pll_locked = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 40)) tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_reset_sequencer.md
Name: pll_lock_reset_sequencer

Overview:
Companion controller for the system PLL. It drives the PLL's reset input and consumes its asynchronous lock indication. It qualifies lock, releases per-domain resets in a fixed order, and re-arms the PLL on lock timeout or lock loss. It sits beside the PLL in the WiMax top level, running on the reference clock, with one reset output per downstream clock domain.

Parameters:
NUM_STAGES, 2, number of downstream domain resets, released in index order 0..NUM_STAGES-1
PLL_RST_CYCLES, 16, cycles pll_rst is held high per PLL reset attempt (>=2)
LOCK_TIMEOUT, 65535, WAIT_LOCK cycles before the PLL is re-reset
STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before release
STAGE_GAP, 64, cycles between successive domain reset releases
CNT_W, 8, width of the saturating event counters

Ports:
refclk  in  1  reference clock; the only clock
rst  in  1  synchronous, active-high reset
pll_locked  in  1  PLL lock indication, asynchronous to refclk
pll_rst  out  1  reset to the PLL, active high
domain_rst  out  NUM_STAGES  per-domain resets, active high
sys_ready  out  1  high when all domains are released and lock holds
lock_loss_cnt  out  CNT_W  lock losses during RELEASE/RUN, saturating
timeout_cnt  out  CNT_W  WAIT_LOCK timeouts, saturating
state  out  3  current state: 0 PLL_RESET, 1 WAIT_LOCK, 2 STABLE, 3 RELEASE, 4 RUN

Behaviour:
- All outputs are registered. Edge n is the n-th rising refclk edge with rst low, n=1 first.
- Reset values: pll_rst=1, domain_rst=all 1, sys_ready=0, both counters=0, state=PLL_RESET, timer=0, stage index=0, sync flops=0.
- pll_locked passes through a 2-flop synchronizer; the result is locked_s. Latency is 2 edges.
- PLL_RESET: pll_rst=1; timer counts 0..PLL_RST_CYCLES-1. At timer==PLL_RST_CYCLES-1: go to WAIT_LOCK, pll_rst<=0, timer<=0.
- WAIT_LOCK:
  - locked_s=1: go to STABLE, timer<=0.
  - Else at timer==LOCK_TIMEOUT-1: go to PLL_RESET, pll_rst<=1, timeout_cnt++ (saturating).
- STABLE:
  - locked_s=0 on any cycle: go to WAIT_LOCK, timer<=0. No counter changes.
  - After STABLE_CYCLES consecutive cycles (timer==STABLE_CYCLES-1 with locked_s=1): go to RELEASE, timer<=0, index<=0.
- RELEASE:
  - At timer==STAGE_GAP-1: domain_rst[index]<=0, timer<=0, index++.
  - When the released index is NUM_STAGES-1: go to RUN and set sys_ready<=1 on the same edge.
  - Resulting timing: domain_rst[k] clears at edge P+1+S+(k+1)G; sys_ready rises at edge P+1+S+N*G. Here P=PLL_RST_CYCLES, S=STABLE_CYCLES, G=STAGE_GAP, N=NUM_STAGES, with pll_locked high from reset.
- Lock loss in RELEASE or RUN (locked_s=0), all on one edge:
  - domain_rst<=all 1, sys_ready<=0
  - lock_loss_cnt++ (saturating)
  - go to PLL_RESET, pll_rst<=1, timer<=0, index<=0
- Lock loss takes priority over a coincident stage release or RUN entry.
- Counters saturate at 2^CNT_W-1 and never wrap. They clear only on rst.
- rst asserted mid-operation: all registers return to reset values on that edge, regardless of state.
- Released resets never re-assert except via lock loss or rst. Release order is strictly ascending.
- Unused state codes 5-7 go to PLL_RESET with reset-value outputs on the next edge.

Test Plan:
1. P=4,S=8,G=4,N=2,LOCK_TIMEOUT=10; pll_locked tied 1; rst high then low -> pll_rst low after edge 4; state=STABLE after edge 5; domain_rst[0]=0 at edge 17; domain_rst[1]=0 and sys_ready=1 at edge 21; counters remain 0.
2. Same params, pll_locked tied 0 -> pll_rst falls after edge 4 and rises after edge 14 with timeout_cnt=1; the cycle repeats every 14 edges; timeout_cnt=3 after edge 42.
3. Lock glitch: drop pll_locked for 1 cycle mid-STABLE -> state returns to WAIT_LOCK; domain_rst stays 2'b11; after lock returns, full S-cycle qualification restarts; lock_loss_cnt=0.
4. Drop pll_locked in RUN -> 2 edges later domain_rst=2'b11, sys_ready=0, pll_rst=1, lock_loss_cnt=1, state=PLL_RESET; with lock restored, re-release follows case 1 timing.
5. Drop pll_locked in RELEASE after domain_rst[0] has cleared -> domain_rst re-asserts to 2'b11, lock_loss_cnt=1; assert rst mid-RELEASE on a separate run -> all reset values on the next edge.
6. CNT_W=2; force 5 timeouts -> timeout_cnt reads 1,2,3,3,3 and never wraps to 0.
